lfsr_rr_scheduler: RTL and testbench



---
 rtl/lfsr_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_lfsr_rr_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_scheduler.sv
// lfsr_rr_scheduler: shares one Fibonacci LFSR among REQ requesters.
// Requesters are picked round-robin and each grant delivers at most BURST
// words, one per cycle, while the owner keeps its request up. The block
// owns seeding (an all-zero seed is replaced by DEFAULT_SEED so the LFSR
// cannot lock up) and flags the word after which the sequence returns to
// the seed.
//
// Handshake: req is a level, not a pulse. A requester is served while its
// req bit is high and gnt shows its one-hot bit; each edge in SERVE with
// req[owner]=1 presents exactly one word (rsp_valid=1, rsp_data, rsp_id).
// There is no backpressure: a word presented with rsp_valid=1 is consumed.
// Dropping req ends the grant without delivering a word on that edge.
module lfsr_rr_scheduler #(
  parameter int             N            = 4,
  parameter logic [N-1:0]   TAPS         = 4'b1100,
  parameter logic [N-1:0]   DEFAULT_SEED = 4'b1111,
  parameter int             REQ          = 3,
  parameter int             BURST        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REQ-1:0]          req,
  input  logic                    load_seed,
  input  logic [N-1:0]            seed_data,
  output logic [REQ-1:0]          gnt,
  output logic                    rsp_valid,
  output logic [N-1:0]            rsp_data,
  output logic [$clog2(REQ)-1:0]  rsp_id,
  output logic                    wrap,
  output logic                    busy
);

  localparam int IDW = $clog2(REQ);
  localparam int CW  = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    SEEDING = 2'd2
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t           state;
  logic [N-1:0]     lfsr;
  logic [N-1:0]     seed_reg;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   owner;
  logic [CW-1:0]    burst_cnt;

  logic [N-1:0]     lfsr_next;
  logic [N-1:0]     seed_sel;
  logic [IDW-1:0]   owner_inc;
  logic             burst_last;
  logic             sel_found;
  logic [IDW-1:0]   sel_idx;
  int               cand;

  // LFSR successor, seed substitution and round-robin helpers
  always_comb begin
    lfsr_next  = {lfsr[N-2:0], ^(lfsr & TAPS)};
    seed_sel   = (seed_data == '0) ? DEFAULT_SEED : seed_data;
    owner_inc  = (int'(owner) == REQ - 1) ? '0 : owner + IDW'(1);
    burst_last = (burst_cnt == CW'(BURST - 1));
  end

  // first requesting index scanning upward from rr_ptr, wrapping at REQ
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 0; i < REQ; i++) begin
      cand = (int'(rr_ptr) + i) % REQ;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(cand);
      end
    end
  end

  // controller: arbitration, burst delivery, seeding; all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= DEFAULT_SEED;
      seed_reg  <= DEFAULT_SEED;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      wrap      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      wrap      <= 1'b0;
      if (load_seed) begin
        lfsr     <= seed_sel;
        seed_reg <= seed_sel;
        gnt      <= '0;
        state    <= SEEDING;
      end else begin
        case (state)
          IDLE: begin
            if (sel_found) begin
              owner     <= sel_idx;
              gnt       <= {{(REQ-1){1'b0}}, 1'b1} << sel_idx;
              burst_cnt <= '0;
              state     <= SERVE;
            end
          end
          SERVE: begin
            if (req[owner]) begin
              rsp_valid <= 1'b1;
              rsp_data  <= lfsr;
              rsp_id    <= owner;
              lfsr      <= lfsr_next;
              burst_cnt <= burst_cnt + CW'(1);
              wrap      <= (lfsr_next == seed_reg);
              if (burst_last) begin
                gnt    <= '0;
                rr_ptr <= owner_inc;
                state  <= IDLE;
              end
            end else begin
              gnt    <= '0;
              rr_ptr <= owner_inc;
              state  <= IDLE;
            end
          end
          SEEDING: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// tb_lfsr_rr_scheduler: directed scenarios plus randomized traffic against a
// transaction-level reference model of the scheduler.
module tb_lfsr_rr_scheduler;

  localparam int R = 3;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic       load_seed;
  logic [3:0] seed_data;
  logic [2:0] gnt;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic [1:0] rsp_id;
  logic       wrap;
  logic       busy;

  lfsr_rr_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .load_seed (load_seed),
    .seed_data (seed_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .wrap      (wrap),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = waiting for arbitration, 1 = serving owner, 2 = seeding
  int m_phase, m_owner, m_ptr, m_count, m_lfsr, m_seed;
  int m_gnt, m_valid, m_data, m_id, m_wrap;
  logic [3:0] exp_q[$];

  // x^4+x^3+1: new bit = bit3 xor bit2, shifted in at the bottom
  function automatic int lfsr_succ(input int v);
    return ((v * 2) % 16) + ($countones(v & 12) % 2);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_count = 0;
    m_lfsr = 15; m_seed = 15;
    m_gnt = 0; m_valid = 0; m_data = 0; m_id = 0; m_wrap = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [2:0] r, input logic ld, input logic [3:0] sd);
    m_valid = 0;
    m_wrap  = 0;
    if (ld) begin
      m_lfsr  = (sd == 0) ? 15 : int'(sd);
      m_seed  = m_lfsr;
      m_gnt   = 0;
      m_phase = 2;
    end else if (m_phase == 0) begin
      if (r != 0) begin
        for (int k = R - 1; k >= 0; k--)
          if (r[(m_ptr + k) % R]) m_owner = (m_ptr + k) % R;
        m_gnt   = 1 << m_owner;
        m_count = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (r[m_owner]) begin
        m_valid = 1;
        m_data  = m_lfsr;
        m_id    = m_owner;
        exp_q.push_back(4'(m_lfsr));
        m_lfsr  = lfsr_succ(m_lfsr);
        m_wrap  = (m_lfsr == m_seed) ? 1 : 0;
        m_count++;
      end
      if (!r[m_owner] || m_count == 4) begin
        m_gnt   = 0;
        m_ptr   = (m_owner + 1) % R;
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    reset = 1'b1; req = '0; load_seed = 1'b0; seed_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_gnt", gnt, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    reset = 1'b0;
  endtask

  // one clock with the given inputs; compares every output against the model
  task automatic cycle(input logic [2:0] r, input logic ld, input logic [3:0] sd);
    req = r; load_seed = ld; seed_data = sd;
    model_step(r, ld, sd);
    @(posedge clk);
    #1;
    check("gnt", gnt, m_gnt);
    check("rsp_valid", rsp_valid, m_valid);
    check("wrap", wrap, m_wrap);
    check("busy", busy, (m_phase != 0) ? 1 : 0);
    check("rsp_id", rsp_id, m_id);
    check("rsp_data", rsp_data, m_data);
    check("gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
    if (rsp_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", rsp_data, 32'hdead);
      else check("sb_word", rsp_data, exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] t2_words [4] = '{4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] t3_words [4] = '{4'h1, 4'h2, 4'h4, 4'h9};
  int         t3_order [4] = '{0, 1, 2, 0};

  initial begin
    int words;
    logic [2:0] r;
    logic       ld;
    logic [3:0] sd;

    // 1/2: single requester, first burst from the default seed
    do_reset();
    cycle(3'b001, 0, 0);
    check("t2_gnt_first", gnt, 3'b001);
    for (int i = 0; i < 4; i++) begin
      cycle(3'b001, 0, 0);
      check("t2_word", rsp_data, t2_words[i]);
    end
    check("t2_gnt_drop", gnt, 0);
    cycle(3'b001, 0, 0);
    check("t2_regrant", gnt, 3'b001);
    check("t2_idle_novalid", rsp_valid, 0);
    cycle(3'b001, 0, 0);
    check("t2_word5", rsp_data, 4'h1);
    cycle(3'b001, 0, 0);
    check("t2_word6", rsp_data, 4'h2);

    // 3: all requesting, round-robin order 0,1,2,0
    do_reset();
    for (int b = 0; b < 4; b++) begin
      cycle(3'b111, 0, 0);
      check("t3_grant", gnt, 1 << t3_order[b]);
      if (b < 3) begin
        for (int i = 0; i < 4; i++) begin
          cycle(3'b111, 0, 0);
          check("t3_id", rsp_id, t3_order[b]);
          if (b == 1) check("t3_owner1_word", rsp_data, t3_words[i]);
        end
      end
    end

    // 4: owner 2 drops after two words, pointer moves on to 0
    do_reset();
    cycle(3'b100, 0, 0);
    check("t4_gnt2", gnt, 3'b100);
    cycle(3'b100, 0, 0);
    cycle(3'b100, 0, 0);
    cycle(3'b001, 0, 0);
    check("t4_release_gnt", gnt, 0);
    check("t4_release_novalid", rsp_valid, 0);
    cycle(3'b001, 0, 0);
    check("t4_next_owner", gnt, 3'b001);

    // 5: reseed mid-burst of owner 1 (zero seed, then 1000)
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      repeat (6) cycle(3'b010, 0, 0);
      cycle(3'b010, 0, 0);
      cycle(3'b010, 0, 0);
      cycle(3'b010, 1, (pass == 0) ? 4'h0 : 4'h8);
      check("t5_abort_gnt", gnt, 0);
      check("t5_abort_novalid", rsp_valid, 0);
      check("t5_seeding_busy", busy, 1);
      cycle(3'b010, 0, 0);
      check("t5_after_seed_idle", busy, 0);
      cycle(3'b010, 0, 0);
      check("t5_regrant", gnt, 3'b010);
      cycle(3'b010, 0, 0);
      check("t5_first_word", rsp_data, (pass == 0) ? 4'hF : 4'h8);
    end

    // 6: full period, wrap only with the 15th word
    do_reset();
    cycle(3'b000, 1, 4'hF);
    words = 0;
    for (int c = 0; c < 40 && words < 16; c++) begin
      cycle(3'b001, 0, 0);
      if (rsp_valid) begin
        words++;
        check("t6_wrap", wrap, (words == 15) ? 1 : 0);
        if (words == 15) check("t6_word15", rsp_data, 4'h7);
        if (words == 16) check("t6_word16", rsp_data, 4'hF);
      end
    end
    check("t6_word_count", words, 16);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) r = 3'b111;
      ld = ($urandom_range(0, 24) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cycle(r, ld, sd);
    end
    repeat (3) cycle(3'b000, 0, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
